// File: rtl/ir_queue.sv
// Instruction prefetch queue between fetch and decode. The head word is
// presented combinationally, already split into opcode and operand fields.
module ir_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int OPC_W = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [OPC_W-1:0]           opcode,
   output logic [WIDTH-OPC_W-1:0]     operand,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   // Status comes only from the registered count, so out_ready never
   // reaches in_ready combinationally.
   assign in_ready  = (r_count != FULL_CNT);
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   assign out_data = r_mem[r_rd_ptr];
   assign opcode   = out_data[WIDTH-1 -: OPC_W];
   assign operand  = out_data[WIDTH-OPC_W-1:0];
   assign count    = r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (!w_push && w_pop)
            r_count <= r_count - 1'b1;
      end
   end

   // Flush drops a coincident push but leaves stored words untouched.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               r_mem[gi] <= '0;
            else if (w_push && !flush && (r_wr_ptr == PTR_W'(gi)))
               r_mem[gi] <= in_data;
         end
      end
   endgenerate

endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue: directed vector table, hand-written corner sequences,
// randomized traffic against a queue model, and a wider parameter instance.
module tb_ir_queue;

   logic       clk;
   logic       reset_n;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] opcode;
   logic [3:0] operand;
   logic [2:0] count;

   logic        p_flush;
   logic        p_in_valid;
   logic [15:0] p_in_data;
   logic        p_in_ready;
   logic        p_out_valid;
   logic        p_out_ready;
   logic [15:0] p_out_data;
   logic [5:0]  p_opcode;
   logic [9:0]  p_operand;
   logic [3:0]  p_count;

   int checks = 0;
   int errors = 0;

   ir_queue #(.WIDTH(8), .DEPTH(4), .OPC_W(4)) u_dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .opcode(opcode), .operand(operand), .count(count)
   );

   ir_queue #(.WIDTH(16), .DEPTH(8), .OPC_W(6)) u_dut16 (
      .clk(clk), .reset_n(reset_n), .flush(p_flush),
      .in_valid(p_in_valid), .in_data(p_in_data), .in_ready(p_in_ready),
      .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
      .opcode(p_opcode), .operand(p_operand), .count(p_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       fl;
      logic       iv;
      logic [7:0] din;
      logic       ordy;
      int         cnt;
      logic       ir;
      logic       ov;
      logic       chk;
      logic [7:0] dout;
   } vec_t;

   vec_t vecs[21];
   logic [7:0] model_q[$];

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d] got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fl, input logic iv, input logic [7:0] d,
                        input logic ordy);
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
   endtask

   // Reference: a plain FIFO governed by the handshake rules.
   task automatic model_step();
      int  sz;
      bit  push, pop;
      sz   = model_q.size();
      push = in_valid && (sz < 4);
      pop  = out_ready && (sz > 0);
      if (flush) model_q.delete();
      else begin
         if (pop)  void'(model_q.pop_front());
         if (push) model_q.push_back(in_data);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      p_flush = 1'b0; p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b0;
      #12 reset_n = 1'b1;
      tick();

      check("rst_count", 0, 32'(count), 0);
      check("rst_in_ready", 0, 32'(in_ready), 1);
      check("rst_out_valid", 0, 32'(out_valid), 0);

      // Asynchronous reset mid-stream: outputs clear without a clock edge.
      drive(1'b0, 1'b1, 8'h5A, 1'b0);
      tick();
      drive(1'b0, 1'b1, 8'h6B, 1'b0);
      tick();
      check("pre_rst_count", 0, 32'(count), 2);
      #3 reset_n = 1'b0;
      #1;
      check("async_count", 0, 32'(count), 0);
      check("async_in_ready", 0, 32'(in_ready), 1);
      check("async_out_valid", 0, 32'(out_valid), 0);
      check("async_out_data", 0, 32'(out_data), 0);
      check("async_opcode", 0, 32'(opcode), 0);
      check("async_operand", 0, 32'(operand), 0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      #2 reset_n = 1'b1;
      tick();
      check("post_rst_count", 0, 32'(count), 0);

      //           fl    iv    din    ordy  cnt ir    ov    chk   dout
      vecs[0]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'hA1};
      vecs[1]  = '{1'b0, 1'b1, 8'hB2, 1'b0, 2, 1'b1, 1'b1, 1'b1, 8'hA1};
      vecs[2]  = '{1'b0, 1'b1, 8'hC3, 1'b0, 3, 1'b1, 1'b1, 1'b1, 8'hA1};
      vecs[3]  = '{1'b0, 1'b1, 8'hD4, 1'b0, 4, 1'b0, 1'b1, 1'b1, 8'hA1};
      vecs[4]  = '{1'b0, 1'b1, 8'hE5, 1'b1, 3, 1'b1, 1'b1, 1'b1, 8'hB2};
      vecs[5]  = '{1'b0, 1'b1, 8'hE5, 1'b0, 4, 1'b0, 1'b1, 1'b1, 8'hB2};
      vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3, 1'b1, 1'b1, 1'b1, 8'hC3};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 1'b1, 8'hD4};
      vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 1'b1, 8'hE5};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[10] = '{1'b0, 1'b1, 8'h21, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'h21};
      vecs[11] = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b1, 1'b1, 1'b1, 8'h21};
      vecs[12] = '{1'b0, 1'b1, 8'h23, 1'b0, 3, 1'b1, 1'b1, 1'b1, 8'h21};
      vecs[13] = '{1'b1, 1'b1, 8'h24, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[14] = '{1'b0, 1'b1, 8'h25, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'h25};
      vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[19] = '{1'b0, 1'b1, 8'h7F, 1'b1, 1, 1'b1, 1'b1, 1'b1, 8'h7F};
      vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};

      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].fl, vecs[i].iv, vecs[i].din, vecs[i].ordy);
         tick();
         check("vec_count", i, 32'(count), 32'(vecs[i].cnt));
         check("vec_in_ready", i, 32'(in_ready), 32'(vecs[i].ir));
         check("vec_out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
         if (vecs[i].chk) check("vec_out_data", i, 32'(out_data), 32'(vecs[i].dout));
         if (i == 3) begin
            check("full_opcode", i, 32'(opcode), 32'h A);
            check("full_operand", i, 32'(operand), 32'h1);
         end
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0);

      // Streaming: one word in and one out every cycle across two wraps.
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b1, 8'(8'h10 + k), 1'b1);
         tick();
         check("stream_count", k, 32'(count), 1);
         check("stream_data", k, 32'(out_data), 32'(8'h10 + k));
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      check("stream_drain", 0, 32'(count), 0);

      // Flush held for several cycles keeps the queue empty despite pushes.
      drive(1'b0, 1'b1, 8'h31, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b1, 8'(8'h40 + k), 1'b0);
         tick();
         check("flush_hold_count", k, 32'(count), 0);
         check("flush_hold_ready", k, 32'(in_ready), 1);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      check("flush_hold_after", 0, 32'(out_valid), 0);

      // Randomized traffic against the reference FIFO.
      model_q.delete();
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 19) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
         model_step();
         tick();
         check("rnd_count", k, 32'(count), 32'(model_q.size()));
         check("rnd_in_ready", k, 32'(in_ready), 32'(model_q.size() != 4));
         check("rnd_out_valid", k, 32'(out_valid), 32'(model_q.size() != 0));
         if (model_q.size() != 0) begin
            check("rnd_out_data", k, 32'(out_data), 32'(model_q[0]));
            check("rnd_opcode", k, 32'(opcode), 32'(model_q[0] >> 4));
            check("rnd_operand", k, 32'(operand), 32'(model_q[0] & 8'h0F));
         end
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0);

      // Wider instance: field split and full at eight entries.
      p_in_valid = 1'b1;
      p_in_data  = 16'hFC03;
      tick();
      check("p_opcode", 0, 32'(p_opcode), 32'h3F);
      check("p_operand", 0, 32'(p_operand), 32'h003);
      check("p_count", 0, 32'(p_count), 1);
      for (int k = 1; k < 8; k++) begin
         p_in_data = 16'(16'h0100 + k);
         tick();
         check("p_fill_count", k, 32'(p_count), 32'(k + 1));
         check("p_fill_ready", k, 32'(p_in_ready), (k == 7) ? 0 : 1);
      end
      p_in_data = 16'hBEEF;
      tick();
      check("p_full_hold", 0, 32'(p_count), 8);
      check("p_head", 0, 32'(p_out_data), 32'hFC03);
      p_in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised successor to the team's single-entry instruction register: a DEPTH-entry instruction prefetch queue with valid/ready handshakes on both sides.
- Sits between the fetch/memory interface and the decoder. Fetch pushes instruction words; the decoder pops them.
- The head entry is presented to the decoder pre-split into opcode and operand fields.
- A synchronous flush discards all queued instructions on branch/jump redirect.

Parameters:
- WIDTH, 8, instruction word width in bits; must be greater than OPC_W.
- DEPTH, 4, number of queue entries; power of 2, at least 2.
- OPC_W, 4, opcode field width; opcode is the top OPC_W bits of the word.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all entries.
- in_valid  in  1  fetch presents a word.
- in_data  in  WIDTH  instruction word from fetch.
- in_ready  out  1  queue can accept a word.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decoder consumes the head.
- out_data  out  WIDTH  head instruction word.
- opcode  out  OPC_W  out_data[WIDTH-1 -: OPC_W].
- operand  out  WIDTH-OPC_W  out_data[WIDTH-OPC_W-1:0].
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-transfer):
  - read/write pointers = 0, count = 0.
  - all storage entries = 0.
  - in_ready = 1, out_valid = 0, out_data/opcode/operand = 0.
  - Reset takes effect immediately, not at the next edge. Operation resumes on the first rising clk after reset_n goes high.
- Handshake rules:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_valid, in_data and out_ready are sampled only on the rising clk edge.
- Status outputs:
  - in_ready = (count != DEPTH). It depends only on registered state: no combinational path from out_ready to in_ready.
  - out_valid = (count != 0).
  - out_data = storage[rd_ptr], combinational from registered state. opcode/operand are pure slices of out_data.
  - Contents are guaranteed only when out_valid = 1. When empty, out_data shows the stale slot at rd_ptr.
- Latency:
  - A word pushed into an empty queue appears with out_valid = 1 on the cycle after the push edge. There is no same-cycle bypass.
- Push only: write storage[wr_ptr], then wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop in the same cycle (only possible when 0 < count < DEPTH): both pointers advance and count is unchanged.
- Full (count = DEPTH):
  - in_ready = 0; a push is not possible even if a pop occurs that cycle.
  - in_ready returns to 1 on the cycle after a pop.
- Empty: pops are impossible; an out_ready asserted while empty is ignored.
- Wrap-around:
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is kept separately, so full and empty are unambiguous.
- Flush (synchronous, highest priority):
  - On an edge with flush = 1: rd_ptr = wr_ptr = 0, count = 0.
  - Any push or pop in that cycle is discarded.
  - Storage contents are left unchanged.
  - Next cycle: out_valid = 0, in_ready = 1.
  - flush held high for several cycles keeps the queue empty.
- Data integrity: words emerge in push order with no loss or duplication across any mix of push, pop, full and wrap events.

Test Plan:
- Reset then fill: drive reset_n = 0 mid-stream → all outputs 0 immediately. Then push 0xA1, 0xB2, 0xC3, 0xD4 with out_ready = 0 → count 1,2,3,4; in_ready = 0 after the 4th push; out_data = 0xA1, opcode = 0xA, operand = 0x1.
- Full backpressure: while full, hold in_valid = 1 with 0xE5 and pulse out_ready once → 0xA1 popped, 0xE5 not accepted that cycle. Next cycle in_ready = 1 and 0xE5 is pushed; drain order is B2, C3, D4, E5.
- Streaming: 10 consecutive words 0x10..0x19 with in_valid = out_ready = 1 continuously → count stays at 1 after the first cycle; outputs 0x10..0x19 in order with one-cycle latency, exercising pointer wrap twice.
- Flush with simultaneous push/pop: count = 3 (0x21, 0x22, 0x23); assert flush with in_valid = 1 (0x24) and out_ready = 1 → next cycle count = 0, out_valid = 0, and 0x24 never appears. A subsequent push of 0x25 emerges next.
- Empty pop: out_ready = 1 with queue empty for 3 cycles, then push 0x7F → count stays 0 during the idle cycles; 0x7F valid the cycle after the push and popped in the same cycle it is seen, leaving count back at 0.
- Parameter sweep: WIDTH = 16, DEPTH = 8, OPC_W = 6; push 0xFC03 → opcode = 0x3F, operand = 0x003. Fill 8 entries → in_ready = 0 at count = 8.
